// File: rtl/sramlike_mem_responder_pkg.sv
// Shared constants and helpers for the sram-like bus memory responder.
package sramlike_mem_responder_pkg;

    localparam logic [2:0] SRL_SIZE_BYTE = 3'd0;
    localparam logic [2:0] SRL_SIZE_HALF = 3'd1;
    localparam logic [2:0] SRL_SIZE_WORD = 3'd2;

    // Width of the per-entry latency countdown; bounds LATENCY to 1..15.
    localparam int SRL_LAT_W = 4;

    function automatic logic srl_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SRL_SIZE_HALF: srl_misaligned = addr_lo[0];
            SRL_SIZE_WORD: srl_misaligned = (addr_lo != 2'b00);
            default:       srl_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sramlike_mem_responder_resp_fifo.sv
// In-order response queue: each entry carries read data and a countdown to its data_ok cycle.
module sramlike_mem_responder_resp_fifo
    import sramlike_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [31:0]          push_data,
    input  logic [SRL_LAT_W-1:0] push_cnt,
    input  logic                 pop,
    output logic                 head_done,
    output logic [31:0]          head_data,
    output logic [PTR_W:0]       count
);

    logic [31:0]          data_q [DEPTH];
    logic [SRL_LAT_W-1:0] cnt_q  [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;

    assign head_done = valid_q[rd_ptr] && (cnt_q[rd_ptr] == '0);
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // Entries keep counting down even behind a stalled head, so a
            // backlog drains one per cycle once the head goes.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                cnt_q[wr_ptr]   <= push_cnt;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sramlike_mem_responder.sv
// Sram-like bus slave backed by a word memory; fixed-latency, in-order responses.
module sramlike_mem_responder
    import sramlike_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        cache,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [SRL_LAT_W-1:0] LAT_CNT = SRL_LAT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2, >= 2");
    end

    logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
    logic [ADDR_BITS-1:0] idx;
    logic [PTR_W:0]       count;
    logic                 accept;
    logic                 head_done;
    logic [31:0]          head_data;
    logic                 unused_ok;

    assign idx = addr[ADDR_BITS+1:2];

    // Full queue blocks acceptance even when the head pops this cycle.
    assign addr_ok = resetn & req & ~addr_stall & (count < (PTR_W + 1)'(DEPTH));
    assign accept  = addr_ok;

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    sramlike_mem_responder_resp_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (wr ? 32'h0 : mem[idx]),
        .push_cnt  (LAT_CNT),
        .pop       (head_done),
        .head_done (head_done),
        .head_data (head_data),
        .count     (count)
    );

    assign data_ok = head_done;
    assign rdata   = head_done ? head_data : 32'h0;

    assign unused_ok = &{1'b0, cache, size, addr[31:ADDR_BITS+2], addr[1:0]};

    a_aligned : assert property (@(posedge clk) disable iff (!resetn)
        accept |-> !srl_misaligned(size, addr[1:0]))
        else $error("misaligned access: size=%0d addr=%h", size, addr);

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Randomized bench: two responders (LATENCY 2 and 8) against a cycle-level queue/array reference.
module tb_sramlike_mem_responder;

    localparam int DEPTH = 4;
    localparam int QCAP  = 16;

    logic        clk;
    logic        resetn_v   [2];
    logic        req_v      [2];
    logic        wr_v       [2];
    logic [2:0]  size_v     [2];
    logic [3:0]  wstrb_v    [2];
    logic [31:0] addr_v     [2];
    logic [31:0] wdata_v    [2];
    logic        cache_v    [2];
    logic        stall_v    [2];
    logic        addr_ok_v  [2];
    logic        data_ok_v  [2];
    logic [31:0] rdata_v    [2];

    int total = 0;
    int bad   = 0;
    int pcyc  = 0;

    // Reference model: memory image plus queue of {data, due cycle} per instance.
    logic [31:0] m_mem  [2][1024];
    logic [31:0] m_d    [2][QCAP];
    int          m_due  [2][QCAP];
    int          m_hd   [2];
    int          m_tl   [2];
    int          m_cnt  [2];
    bit          armed  [2];
    int          n_resp [2];
    logic [31:0] last_rdata [2];
    logic [31:0] init_val [2][64];

    sramlike_mem_responder #(.ADDR_BITS(10), .LATENCY(2), .DEPTH(DEPTH)) u_dut_l2 (
        .clk(clk), .resetn(resetn_v[0]), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
        .wstrb(wstrb_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .cache(cache_v[0]),
        .addr_stall(stall_v[0]), .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]), .rdata(rdata_v[0])
    );

    sramlike_mem_responder #(.ADDR_BITS(10), .LATENCY(8), .DEPTH(DEPTH)) u_dut_l8 (
        .clk(clk), .resetn(resetn_v[1]), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
        .wstrb(wstrb_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .cache(cache_v[1]),
        .addr_stall(stall_v[1]), .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]), .rdata(rdata_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, pcyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          lat;
            int          widx;
            bit          e_aok;
            bit          e_dok;
            logic [31:0] e_rd;
            lat   = (k == 0) ? 2 : 8;
            e_aok = resetn_v[k] && req_v[k] && !stall_v[k] && (m_cnt[k] < DEPTH);
            e_dok = (m_cnt[k] > 0) && (m_due[k][m_hd[k]] <= pcyc);
            e_rd  = e_dok ? m_d[k][m_hd[k]] : 32'h0;
            if (armed[k]) begin
                chk($sformatf("L%0d addr_ok", lat), {31'h0, addr_ok_v[k]}, {31'h0, e_aok});
                chk($sformatf("L%0d data_ok", lat), {31'h0, data_ok_v[k]}, {31'h0, e_dok});
                chk($sformatf("L%0d rdata", lat), rdata_v[k], e_rd);
            end
            if (data_ok_v[k] === 1'b1) begin
                n_resp[k]++;
                last_rdata[k] = rdata_v[k];
            end
            // Apply what the coming posedge will do.
            if (!resetn_v[k]) begin
                m_cnt[k] = 0;
                m_hd[k]  = 0;
                m_tl[k]  = 0;
                armed[k] = 1'b1;
            end else begin
                if (e_dok) begin
                    m_hd[k] = (m_hd[k] + 1) % QCAP;
                    m_cnt[k]--;
                end
                if (e_aok) begin
                    widx = int'(addr_v[k][11:2]);
                    if (wr_v[k]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_v[k][b]) m_mem[k][widx][8*b +: 8] = wdata_v[k][8*b +: 8];
                        end
                        m_d[k][m_tl[k]] = 32'h0;
                    end else begin
                        m_d[k][m_tl[k]] = m_mem[k][widx];
                    end
                    m_due[k][m_tl[k]] = pcyc + lat;
                    m_tl[k] = (m_tl[k] + 1) % QCAP;
                    m_cnt[k]++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int stl, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        wr_v[k]    = w;
        addr_v[k]  = a;
        wdata_v[k] = d;
        wstrb_v[k] = s;
        size_v[k]  = 3'd2;
        cache_v[k] = 1'($urandom_range(0, 1));
        req_v[k]   = 1'b1;
        if (stl > 0) begin
            stall_v[k] = 1'b1;
            idle(stl);
            stall_v[k] = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (addr_ok_v[k] === 1'b1) begin
                ok  = 1'b1;
                acc = pcyc;
                break;
            end
        end
        if (!ok) chk("accept timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_v[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 64 && m_cnt[k] != 0; i++) idle(1);
        idle(1);
        chk("drain timeout", m_cnt[k], 32'h0);
    endtask

    initial begin
        int          acc;
        int          st;
        int          n0;
        int          accs [8];
        int          ridx;
        logic [31:0] v;

        for (int k = 0; k < 2; k++) begin
            resetn_v[k] = 1'b0; req_v[k] = 1'b0; wr_v[k] = 1'b0; size_v[k] = 3'd2;
            wstrb_v[k] = 4'h0; addr_v[k] = 32'h0; wdata_v[k] = 32'h0;
            cache_v[k] = 1'b0; stall_v[k] = 1'b0;
            m_hd[k] = 0; m_tl[k] = 0; m_cnt[k] = 0; n_resp[k] = 0; last_rdata[k] = 32'h0;
        end
        #1;
        idle(3);
        resetn_v[0] = 1'b1;
        resetn_v[1] = 1'b1;

        // Word write then read-back, accepted in the request cycle.
        st = pcyc;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, acc);
        chk("t1 write accept cycle", acc, st);
        st = pcyc;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
        chk("t1 read accept cycle", acc, st);
        drain(0);
        chk("t1 read data", last_rdata[0], 32'hDEADBEEF);

        // Byte strobes merge into the stored word.
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, acc);
        issue(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, acc);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, acc);
        drain(0);
        chk("t2 strobe merge", last_rdata[0], 32'h1122AA44);

        // Known contents for words 0..63 in both memories.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                v = $urandom;
                init_val[k][i] = v;
                issue(k, 1'b1, 32'(i * 4), v, 4'hF, 0, acc);
            end
            drain(k);
        end

        // Eight back-to-back reads at LATENCY 2.
        n0 = n_resp[0];
        for (int i = 0; i < 8; i++) begin
            issue(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, acc);
            accs[i] = acc;
        end
        chk("t3 accept span", 32'(accs[7] - accs[0]), 32'd7);
        drain(0);
        chk("t3 response count", 32'(n_resp[0] - n0), 32'd8);
        chk("t3 last data", last_rdata[0], init_val[0][7]);

        // Stall holds the request; one accept, one response.
        n0 = n_resp[0];
        issue(0, 1'b0, 32'h14, 32'h0, 4'h0, 3, acc);
        drain(0);
        chk("t5 response count", 32'(n_resp[0] - n0), 32'd1);
        chk("t5 data", last_rdata[0], init_val[0][5]);

        // LATENCY 8 fills the queue; fifth accept waits for the first pop.
        n0 = n_resp[1];
        for (int i = 0; i < 6; i++) begin
            issue(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, acc);
            accs[i] = acc;
        end
        chk("t4 fourth accept", 32'(accs[3] - accs[0]), 32'd3);
        chk("t4 fifth accept", 32'(accs[4] - accs[0]), 32'd9);
        chk("t4 sixth accept", 32'(accs[5] - accs[4]), 32'd1);
        drain(1);
        chk("t4 response count", 32'(n_resp[1] - n0), 32'd6);
        chk("t4 last data", last_rdata[1], init_val[1][5]);

        // Reset with three reads outstanding discards them.
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 32'(32'h30 + i * 4), 32'h0, 4'h0, 0, acc);
        resetn_v[1] = 1'b0;
        idle(1);
        resetn_v[1] = 1'b1;
        n0 = n_resp[1];
        idle(12);
        chk("t6 no response after reset", 32'(n_resp[1] - n0), 32'd0);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
        drain(1);
        chk("t6 response count", 32'(n_resp[1] - n0), 32'd1);
        chk("t6 memory retained", last_rdata[1], init_val[1][4]);

        // Random mix: reads, partial writes, stalls, gaps, ignored upper address bits.
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 150; t++) begin
                ridx = $urandom_range(0, 63);
                issue(k, 1'($urandom_range(0, 1)),
                      ($urandom & 32'hFFFF_F000) | 32'(ridx * 4),
                      $urandom, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, acc);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            drain(k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
